serial_mag_comp: RTL and testbench

SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

---
 rtl/serial_mag_comp.sv | 154 +++++++++++++++
 tb/tb_serial_mag_comp.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// -----------------------------------------------------------------------------
// serial_mag_comp
//
// Bit-serial unsigned magnitude comparator. Two WIDTH-bit operands arrive one
// bit pair per accepted cycle, MSB first. The first differing pair fixes the
// outcome; eq/gt/lt are presented with a one-cycle done pulse and then held
// until the next accepted start or reset.
//
// Optional feature (compile-time macro):
//   SERIAL_COMP_EARLY_DONE_EN - finish as soon as the first differing pair is
//   consumed instead of always waiting for all WIDTH pairs. Equal operands
//   still take WIDTH pairs.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   begin a new comparison (also aborts one in progress)
//   bit_valid  in   a_bit/b_bit hold a valid pair this cycle
//   a_bit      in   operand A bit, MSB first
//   b_bit      in   operand B bit, MSB first
//   busy       out  comparison in progress, accepting bits
//   done       out  one-cycle pulse, result valid from this cycle
//   eq/gt/lt   out  result flags (unsigned), one-hot at done
//   bit_cnt    out  bit pairs consumed in the current comparison
// -----------------------------------------------------------------------------
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         bit_valid,
  input  logic                         a_bit,
  input  logic                         b_bit,
  output logic                         busy,
  output logic                         done,
  output logic                         eq,
  output logic                         gt,
  output logic                         lt,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int                CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic decided;   // a differing pair has been seen in this word
  logic gt_int;    // decision taken at that pair
  logic lt_int;
  logic consume;   // a bit pair is accepted at the coming edge
  logic word_end;  // COMPARE has gathered enough to report

  // A start always wins: it aborts a word in progress and discards any pair
  // presented alongside it. Once WIDTH pairs are in, extra pairs are dropped so
  // bit_cnt saturates.
`ifdef SERIAL_COMP_EARLY_DONE_EN
  assign consume  = (state == S_COMPARE) && !start && bit_valid &&
                    (bit_cnt != CNT_MAX) && !decided;
  assign word_end = (bit_cnt == CNT_MAX) || decided;
`else
  assign consume  = (state == S_COMPARE) && !start && bit_valid &&
                    (bit_cnt != CNT_MAX);
  assign word_end = (bit_cnt == CNT_MAX);
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_COMPARE;
    end else begin
      unique case (state)
        S_IDLE:    state_nxt = S_IDLE;
        S_COMPARE: state_nxt = word_end ? S_DONE : S_COMPARE;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_COMPARE: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: pair counter, decision flags, held result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      decided <= 1'b0;
      gt_int  <= 1'b0;
      lt_int  <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
    end else if (start) begin
      bit_cnt <= '0;
      decided <= 1'b0;
      gt_int  <= 1'b0;
      lt_int  <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      if (consume) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        // MSB-first: the first differing pair decides; later pairs are ignored.
        if (!decided && (a_bit != b_bit)) begin
          decided <= 1'b1;
          gt_int  <= a_bit & ~b_bit;
          lt_int  <= ~a_bit & b_bit;
        end
      end
      // Result is latched on the edge entering DONE and held afterwards.
      if ((state == S_COMPARE) && word_end) begin
        eq <= ~decided;
        gt <= gt_int;
        lt <= lt_int;
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comp
//
// Self-checking bench for serial_mag_comp (WIDTH = 8). Inputs are driven and
// outputs sampled on the falling clock edge. Expected results come from plain
// integer comparison of the operands; the number of pairs a word needs comes
// from the position of the first differing bit (early-done build) or WIDTH.
// -----------------------------------------------------------------------------
module tb_serial_mag_comp;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          bit_valid;
  logic          a_bit;
  logic          b_bit;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic          lt;
  logic [CW-1:0] bit_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_mag_comp #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .bit_cnt   (bit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pairs the DUT must consume before it reports.
  function automatic int pairs_needed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int first_diff;
    first_diff = WIDTH;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        first_diff = WIDTH - i;
        break;
      end
    end
`ifdef SERIAL_COMP_EARLY_DONE_EN
    return first_diff;
`else
    return (first_diff > 0) ? WIDTH : WIDTH;
`endif
  endfunction

  function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    return {ua == ub, ua > ub, ua < ub};
  endfunction

  // All tasks are entered at a falling edge with inputs free to drive.
  task automatic start_word();
    start     = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    a_bit     = 1'($urandom_range(0, 1));
    b_bit     = 1'($urandom_range(0, 1));
    @(negedge clk);
    start     = 1'b0;
    bit_valid = 1'b0;
    check("start_busy",  busy,         1);
    check("start_done",  done,         0);
    check("start_cnt",   bit_cnt,      0);
    check("start_flags", {eq, gt, lt}, 3'b000);
  endtask

  // mode: 0 continuous, 1 toggling 1/0, 2 random stalls
  task automatic feed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int mode, input int n);
    int consumed;
    int cyc;
    logic v;
    consumed = 0;
    cyc      = 0;
    while (consumed < n) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bit_valid = v;
      if (v) begin
        a_bit = a[WIDTH-1-consumed];
        b_bit = b[WIDTH-1-consumed];
      end else begin
        a_bit = 1'($urandom_range(0, 1));
        b_bit = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (v) consumed++;
      cyc++;
      check("feed_cnt",  bit_cnt, 32'(consumed));
      check("feed_done", done,    0);
      check("feed_busy", busy,    1);
    end
    bit_valid = 1'b0;
  endtask

  // Called right after the last needed pair was consumed. Extra valid pairs
  // are driven throughout and must be ignored.
  task automatic finish(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit b2b);
    int n;
    logic [2:0] f;
    n = pairs_needed(a, b);
    f = ref_flags(a, b);
    check("wait_done", done, 0);
    bit_valid = 1'b1;
    a_bit     = 1'($urandom_range(0, 1));
    b_bit     = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("done_pulse", done,         1);
    check("done_busy",  busy,         0);
    check("done_flags", {eq, gt, lt}, f);
    check("done_cnt",   bit_cnt,      32'(n));
    if (b2b) return;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    check("post_done",  done,         0);
    check("post_busy",  busy,         0);
    check("post_flags", {eq, gt, lt}, f);
    check("post_cnt",   bit_cnt,      32'(n));
  endtask

  task automatic run_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int mode);
    start_word();
    feed(a, b, mode, pairs_needed(a, b));
    finish(a, b, 1'b0);
  endtask

  task automatic idle_hold(input int cycles, input logic [2:0] f, input int n);
    for (int i = 0; i < cycles; i++) begin
      bit_valid = 1'b1;
      a_bit     = 1'($urandom_range(0, 1));
      b_bit     = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_cnt",   bit_cnt,      32'(n));
      check("idle_flags", {eq, gt, lt}, f);
      check("idle_busy",  busy,         0);
      check("idle_done",  done,         0);
    end
    bit_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},  busy,         0);
    check({tag, "_done"},  done,         0);
    check({tag, "_flags"}, {eq, gt, lt}, 3'b000);
    check({tag, "_cnt"},   bit_cnt,      0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    int n_ab;
    int sel;
    bit b2b;

    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Directed words
    run_word(8'hA5, 8'hA5, 0);
    run_word(8'h80, 8'h7F, 0);
    run_word(8'h3C, 8'h3D, 1);

    // Abort: partial 0xFF vs 0x00, restart with valid pair discarded, then 0x12 vs 0x12
    start_word();
    n_ab = (pairs_needed(8'hFF, 8'h00) > 4) ? 4 : pairs_needed(8'hFF, 8'h00) - 1;
    feed(8'hFF, 8'h00, 0, n_ab);
    start_word();
    feed(8'h12, 8'h12, 0, pairs_needed(8'h12, 8'h12));
    finish(8'h12, 8'h12, 1'b0);

    // bit_valid pulses while idle must change nothing
    idle_hold(4, 3'b100, WIDTH);

    // Reset mid-word, with start and bit_valid asserted alongside
    start_word();
    feed(8'h5A, 8'h5A, 0, 5);
    rst = 1'b1; start = 1'b1; bit_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
    check_cleared("midrst");
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      @(negedge clk);
      check_cleared("after_rst");
    end
    bit_valid = 1'b0;
    run_word(8'hC3, 8'hC1, 2);

    // Randomized words, some started straight from DONE
    for (int k = 0; k < 40; k++) begin
      a   = WIDTH'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0)      b = a;
      else if (sel == 1) b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      else               b = WIDTH'($urandom);
      b2b = (k != 39) && ($urandom_range(0, 2) == 0);
      start_word();
      feed(a, b, $urandom_range(0, 2), pairs_needed(a, b));
      finish(a, b, b2b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
